// File: rtl/bus_if_split_if.sv
// Point-to-point request/response bus between one master and one slave.
// Command, write data and byte enables travel together; one response per command.
interface bus_if_split_if (
  input logic Clk
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 3;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic                MReset_n;
  logic [CMD_W-1:0]    MCmd;
  logic [ADDR_W-1:0]   MAddr;
  logic [DATA_W-1:0]   MData;
  logic                MDataValid;
  logic [BE_W-1:0]     MByteEn;
  logic                SCmdAccept;
  logic                SDataAccept;
  logic [RESP_W-1:0]   SResp;
  logic [DATA_W-1:0]   SData;
  logic                MRespAccept;

  modport master (
    input  Clk,
    output MReset_n, MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept,
    input  SCmdAccept, SDataAccept, SResp, SData
  );

  modport slave (
    input  Clk,
    input  MReset_n, MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept,
    output SCmdAccept, SDataAccept, SResp, SData
  );
endinterface

// File: rtl/bus_if_split.sv
// Address-decoding 1-to-2 bus splitter; a small destination FIFO keeps
// responses to the master in command order.
module bus_if_split #(
  parameter logic [31:0]  OUT1_BASE     = 32'h8000_0000,
  parameter logic [31:0]  OUT1_MASK     = 32'h8000_0000,
  parameter int unsigned  NUM_IN_FLIGHT = 4
) (
  input logic          Clk,
  input logic          Reset,
  bus_if_split_if.slave  in,
  bus_if_split_if.master out_0,
  bus_if_split_if.master out_1
);
  localparam int unsigned PTR_W = (NUM_IN_FLIGHT > 1) ? $clog2(NUM_IN_FLIGHT) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_IN_FLIGHT + 1);
  localparam logic [2:0]  CMD_IDLE  = 3'd0;
  localparam logic [1:0]  RESP_NULL = 2'd0;

  logic [NUM_IN_FLIGHT-1:0] dest_q;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     empty;
  logic                     sel;
  logic                     cmd_ok;
  logic                     sel_accept;
  logic                     push;
  logic                     head;
  logic                     resp_ok;
  logic [1:0]               head_resp;
  logic                     pop;

  assign full  = (count == CNT_W'(NUM_IN_FLIGHT));
  assign empty = (count == CNT_W'(0));
  assign head  = dest_q[rd_ptr];

  assign out_0.MReset_n = ~Reset;
  assign out_1.MReset_n = ~Reset;

  // Request decode and accept: forward only to the selected port, only when there is room.
  always_comb begin
    sel               = ((in.MAddr & OUT1_MASK) == OUT1_BASE);
    cmd_ok            = !Reset && !full && (in.MCmd != CMD_IDLE);
    out_0.MCmd        = CMD_IDLE;
    out_0.MAddr       = '0;
    out_0.MData       = '0;
    out_0.MDataValid  = 1'b0;
    out_0.MByteEn     = '0;
    out_1.MCmd        = CMD_IDLE;
    out_1.MAddr       = '0;
    out_1.MData       = '0;
    out_1.MDataValid  = 1'b0;
    out_1.MByteEn     = '0;
    if (cmd_ok) begin
      if (sel) begin
        out_1.MCmd       = in.MCmd;
        out_1.MAddr      = in.MAddr;
        out_1.MData      = in.MData;
        out_1.MDataValid = in.MDataValid;
        out_1.MByteEn    = in.MByteEn;
      end else begin
        out_0.MCmd       = in.MCmd;
        out_0.MAddr      = in.MAddr;
        out_0.MData      = in.MData;
        out_0.MDataValid = in.MDataValid;
        out_0.MByteEn    = in.MByteEn;
      end
    end
    sel_accept     = sel ? out_1.SCmdAccept : out_0.SCmdAccept;
    push           = cmd_ok && sel_accept;
    in.SCmdAccept  = push;
    in.SDataAccept = push;
  end

  // Response return: only the port at the FIFO head is listened to.
  always_comb begin
    resp_ok           = !Reset && !empty;
    in.SResp          = RESP_NULL;
    in.SData          = '0;
    out_0.MRespAccept = 1'b0;
    out_1.MRespAccept = 1'b0;
    head_resp         = head ? out_1.SResp : out_0.SResp;
    if (resp_ok) begin
      if (head) begin
        in.SResp          = out_1.SResp;
        in.SData          = out_1.SData;
        out_1.MRespAccept = in.MRespAccept;
      end else begin
        in.SResp          = out_0.SResp;
        in.SData          = out_0.SData;
        out_0.MRespAccept = in.MRespAccept;
      end
    end
    pop = resp_ok && in.MRespAccept && (head_resp != RESP_NULL);
  end

  // FIFO payload needs no reset; stale entries are never read while empty.
  always_ff @(posedge Clk) begin
    if (push) begin
      dest_q[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(NUM_IN_FLIGHT - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(NUM_IN_FLIGHT - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_if_split.sv
// Directed bench for bus_if_split: stimulus pushes expected response data,
// a negedge monitor pops and compares every response handshake on in.
module tb_bus_if_split;
  localparam int unsigned NIF      = 4;
  localparam logic [2:0]  IDLE     = 3'd0;
  localparam logic [2:0]  WRITE    = 3'd1;
  localparam logic [2:0]  READ     = 3'd2;
  localparam logic [1:0]  DVA      = 2'd1;
  localparam logic [1:0]  RNULL    = 2'd0;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  bus_if_split_if in_if (.Clk(Clk));
  bus_if_split_if o0_if (.Clk(Clk));
  bus_if_split_if o1_if (.Clk(Clk));

  bus_if_split #(
    .OUT1_BASE(32'h8000_0000), .OUT1_MASK(32'h8000_0000), .NUM_IN_FLIGHT(NIF)
  ) dut (
    .Clk(Clk), .Reset(Reset), .in(in_if), .out_0(o0_if), .out_1(o1_if)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    in_if.MCmd       = cmd;
    in_if.MAddr      = addr;
    in_if.MData      = data;
    in_if.MDataValid = (cmd == WRITE);
    in_if.MByteEn    = (cmd == WRITE) ? 4'hF : 4'h0;
  endtask

  task automatic slave_resp(input int port, input logic [1:0] resp, input logic [31:0] data);
    if (port == 0) begin
      o0_if.SResp = resp;
      o0_if.SData = data;
    end else begin
      o1_if.SResp = resp;
      o1_if.SData = data;
    end
  endtask

  // Response scoreboard plus occupancy model for full/empty checks.
  always @(negedge Clk) begin
    automatic logic do_push = in_if.SCmdAccept;
    automatic logic do_pop  = (in_if.SResp != RNULL) && in_if.MRespAccept;
    if (model_cnt == 0) check("no_resp_when_empty", 32'(in_if.SResp), 32'(RNULL));
    if (model_cnt == NIF) check("no_push_when_full", 32'(in_if.SCmdAccept), 32'd0);
    if (do_pop) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL resp_unexpected: got %h expected none", in_if.SData);
      end else begin
        check("resp_data", in_if.SData, exp_q.pop_front());
      end
    end
    if (Reset) model_cnt = 0;
    else model_cnt = model_cnt + int'(do_push) - int'(do_pop);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    in_if.MReset_n = 1'b1;
    in_if.MRespAccept = 1'b1;
    drive_cmd(READ, 32'h0000_0040, 32'h0);
    o0_if.SCmdAccept = 1'b1; o0_if.SDataAccept = 1'b1;
    o1_if.SCmdAccept = 1'b1; o1_if.SDataAccept = 1'b1;
    slave_resp(0, DVA, 32'h1111_1111);
    slave_resp(1, DVA, 32'h2222_2222);
    tick();
    @(negedge Clk);
    check("rst_in_accept", 32'(in_if.SCmdAccept), 32'd0);
    check("rst_in_sresp", 32'(in_if.SResp), 32'(RNULL));
    check("rst_o0_mcmd", 32'(o0_if.MCmd), 32'(IDLE));
    check("rst_o0_mreset_n", 32'(o0_if.MReset_n), 32'd0);
    check("rst_o1_mrespaccept", 32'(o1_if.MRespAccept), 32'd0);
    tick();
    Reset = 1'b0;
    drive_cmd(IDLE, 32'h0, 32'h0);
    slave_resp(0, RNULL, 32'h0);
    slave_resp(1, RNULL, 32'h0);
    @(negedge Clk);
    check("idle_o1_mreset_n", 32'(o1_if.MReset_n), 32'd1);
    check("idle_o0_mrespaccept", 32'(o0_if.MRespAccept), 32'd0);

    // T1: single read to out_0
    tick();
    drive_cmd(READ, 32'h0000_0010, 32'h0);
    @(negedge Clk);
    check("t1_o0_mcmd", 32'(o0_if.MCmd), 32'(READ));
    check("t1_o1_mcmd", 32'(o1_if.MCmd), 32'(IDLE));
    check("t1_o0_maddr", o0_if.MAddr, 32'h0000_0010);
    check("t1_accept", 32'(in_if.SCmdAccept), 32'd1);
    exp_q.push_back(32'hCAFE_0001);
    tick();
    drive_cmd(IDLE, 32'h0, 32'h0);
    slave_resp(0, DVA, 32'hCAFE_0001);
    @(negedge Clk);
    check("t1_o0_mrespaccept", 32'(o0_if.MRespAccept), 32'd1);
    tick();
    slave_resp(0, RNULL, 32'h0);

    // T2: out_0 answers first but must wait for out_1
    drive_cmd(READ, 32'h8000_0004, 32'h0);
    @(negedge Clk);
    check("t2_o1_mcmd", 32'(o1_if.MCmd), 32'(READ));
    check("t2_o0_mcmd_idle", 32'(o0_if.MCmd), 32'(IDLE));
    exp_q.push_back(32'hBBBB_0001);
    tick();
    drive_cmd(READ, 32'h0000_0004, 32'h0);
    @(negedge Clk);
    check("t2_o0_mcmd", 32'(o0_if.MCmd), 32'(READ));
    check("t2_accept2", 32'(in_if.SCmdAccept), 32'd1);
    exp_q.push_back(32'hAAAA_0002);
    tick();
    drive_cmd(IDLE, 32'h0, 32'h0);
    slave_resp(0, DVA, 32'hAAAA_0002);
    @(negedge Clk);
    check("t2_o0_held", 32'(o0_if.MRespAccept), 32'd0);
    check("t2_in_null", 32'(in_if.SResp), 32'(RNULL));
    tick();
    @(negedge Clk);
    check("t2_o0_held2", 32'(o0_if.MRespAccept), 32'd0);
    tick();
    slave_resp(1, DVA, 32'hBBBB_0001);
    @(negedge Clk);
    check("t2_o1_mrespaccept", 32'(o1_if.MRespAccept), 32'd1);
    check("t2_o0_held3", 32'(o0_if.MRespAccept), 32'd0);
    tick();
    slave_resp(1, RNULL, 32'h0);
    @(negedge Clk);
    check("t2_o0_released", 32'(o0_if.MRespAccept), 32'd1);
    tick();
    slave_resp(0, RNULL, 32'h0);

    // T3/T6: fill to capacity, then a same-cycle pop must not unblock the push
    for (int i = 0; i < 4; i++) begin
      drive_cmd(READ, 32'h0000_0100 + 32'(i * 4), 32'h0);
      @(negedge Clk);
      check($sformatf("t3_accept%0d", i), 32'(in_if.SCmdAccept), 32'd1);
      exp_q.push_back(32'hD000_0000 + 32'(i));
      tick();
    end
    drive_cmd(READ, 32'h0000_0110, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check("t3_full_accept", 32'(in_if.SCmdAccept), 32'd0);
      check("t3_full_o0_idle", 32'(o0_if.MCmd), 32'(IDLE));
      tick();
    end
    slave_resp(0, DVA, 32'hD000_0000);
    @(negedge Clk);
    check("t6_pop_no_push", 32'(in_if.SCmdAccept), 32'd0);
    check("t6_pop_accept", 32'(o0_if.MRespAccept), 32'd1);
    tick();
    slave_resp(0, RNULL, 32'h0);
    @(negedge Clk);
    check("t6_push_next", 32'(in_if.SCmdAccept), 32'd1);
    exp_q.push_back(32'hD000_0004);
    tick();
    drive_cmd(IDLE, 32'h0, 32'h0);
    for (int i = 1; i < 5; i++) begin
      slave_resp(0, DVA, 32'hD000_0000 + 32'(i));
      tick();
    end
    slave_resp(0, RNULL, 32'h0);

    // T4: write to out_1 stalled by the slave for three cycles
    o1_if.SCmdAccept = 1'b0;
    drive_cmd(WRITE, 32'h8000_0100, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("t4_stall_accept", 32'(in_if.SCmdAccept), 32'd0);
      check("t4_o1_mcmd", 32'(o1_if.MCmd), 32'(WRITE));
      tick();
    end
    o1_if.SCmdAccept = 1'b1;
    @(negedge Clk);
    check("t4_accept", 32'(in_if.SCmdAccept), 32'd1);
    check("t4_data_accept", 32'(in_if.SDataAccept), 32'd1);
    check("t4_o1_mdata", o1_if.MData, 32'h1234_5678);
    exp_q.push_back(32'h0000_0000);
    tick();
    drive_cmd(IDLE, 32'h0, 32'h0);
    slave_resp(1, DVA, 32'h0000_0000);
    @(negedge Clk);
    check("t4_o1_mrespaccept", 32'(o1_if.MRespAccept), 32'd1);
    tick();
    slave_resp(1, RNULL, 32'h0);

    // T5: reset with two reads outstanding drops them
    for (int i = 0; i < 2; i++) begin
      drive_cmd(READ, 32'h0000_0200 + 32'(i * 4), 32'h0);
      tick();
    end
    Reset = 1'b1;
    drive_cmd(READ, 32'h0000_0020, 32'h0);
    @(negedge Clk);
    check("t5_rst_accept", 32'(in_if.SCmdAccept), 32'd0);
    tick();
    Reset = 1'b0;
    slave_resp(0, DVA, 32'h5555_5555);
    @(negedge Clk);
    check("t5_in_null", 32'(in_if.SResp), 32'(RNULL));
    check("t5_o0_mrespaccept", 32'(o0_if.MRespAccept), 32'd0);
    check("t5_o1_mrespaccept", 32'(o1_if.MRespAccept), 32'd0);
    check("t5_new_accept", 32'(in_if.SCmdAccept), 32'd1);
    exp_q.push_back(32'hEEEE_0005);
    tick();
    drive_cmd(IDLE, 32'h0, 32'h0);
    slave_resp(0, DVA, 32'hEEEE_0005);
    tick();
    slave_resp(0, RNULL, 32'h0);
    tick();
    tick();
    @(negedge Clk);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
